mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 16, cycles waited for dmem_ack before aborting (legal 1..255).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high reset
  in_valid  in  1  EX_MEM slot holds a valid instruction
  ALU_Result  in  64  effective address / ALU value
  write_data  in  64  store data (rs2)
  rd  in  5  destination register
  funct3  in  3  access size/sign
  MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control from EX_MEM
  stall  out  1  upstream SHALL hold inputs while high
  dmem_req  out  1  bus request
  dmem_we  out  1  1 = store
  dmem_addr  out  64  doubleword-aligned address {ALU_Result[63:3],3'b000}
  dmem_wdata  out  64  lane-shifted store data
  dmem_wstrb  out  8  byte enables
  dmem_ack  in  1  bus completion, one-cycle pulse
  dmem_rdata  in  64  read doubleword, valid with dmem_ack
  out_valid  out  1  result valid toward MEM_WB
  read_data  out  64  aligned, extended load data
  ALU_Result_out, rd_out, RegWrite_out, MemtoReg_out, MemRead_out  out  64/5/1/1/1  forwarded to MEM_WB
  bus_error  out  1  timeout abort pulse
  misalign_trap  out  1  misaligned access pulse

Function
REQ-003 States IDLE, WAIT_ACK; mem_op = MemRead|MemWrite.
REQ-004 IDLE, in_valid, !mem_op: capture inputs, out_valid=1 next cycle (latency 1), read_data=0, stay IDLE.
REQ-005 IDLE, in_valid, mem_op: capture request, go WAIT_ACK; dmem_req=1 from next cycle until ack/abort.
REQ-006 stall = (IDLE & in_valid & mem_op) | (WAIT_ACK & !dmem_ack & !timeout).
REQ-007 Inputs ignored in WAIT_ACK; dmem_* outputs held stable while dmem_req=1.
REQ-008 WAIT_ACK & dmem_ack: capture formatted dmem_rdata, out_valid=1 next cycle, return IDLE; new op acceptable the cycle after.
REQ-009 Wait counter clears on WAIT_ACK entry; at count==MAX_WAIT without ack: abort, bus_error and out_valid pulse one cycle with RegWrite_out=0, return IDLE.
REQ-010 Store lanes: off=addr[2:0]; SB/SH/SW/SD (funct3 000/001/010/011) wstrb=0x01/0x03/0x0F/0xFF << off, wdata=write_data << 8*off, bits beyond 8 lanes dropped.
REQ-011 Loads: data=dmem_rdata >> 8*off; LB/LH/LW sign-extend, LBU/LHU/LWU (100/101/110) zero-extend, LD 011 and 111 as 64-bit.
REQ-012 dmem_ack in IDLE SHALL be ignored; out_valid, bus_error, misalign_trap are single-cycle pulses.

Reset
REQ-013 Reset: state IDLE, counter 0, all outputs 0 at next edge, including mid-WAIT_ACK (dmem_req drops, pending access discarded, no out_valid).

Configuration
REQ-014 MISALIGN_TRAP_EN defined: H addr[0]!=0, W addr[1:0]!=0, D addr[2:0]!=0 -> no bus request, stall 0, next cycle out_valid and misalign_trap pulse, RegWrite_out=0.
REQ-015 MISALIGN_TRAP_EN undefined: misalign_trap tied 0; access performed per REQ-010/011 with truncation.

Structure
REQ-016 Package mem_pkg SHALL hold funct3 load/store encodings and state enum.
REQ-017 Combinational sub-module mem_load_align SHALL do shift and sign/zero extension.

Verification
REQ-018 ALU op, in_valid=1, RegWrite=1, rd=5 -> out_valid next cycle, rd_out=5, no dmem_req.
REQ-019 LB addr 0x1003, ack 2 cycles later, rdata=0x00000000_80000000 -> read_data=0xFFFF_FFFF_FFFF_FF80, stall high until ack cycle.
REQ-020 SH addr 0x2006, write_data=0xBEEF -> dmem_addr=0x2000, wstrb=0xC0, wdata=0xBEEF_0000_0000_0000.
REQ-021 LD, no ack, MAX_WAIT=16 -> bus_error pulse 16 cycles after dmem_req rise, RegWrite_out=0, IDLE.
REQ-022 Reset asserted during WAIT_ACK, ack arrives next -> dmem_req 0, out_valid never pulses.
REQ-023 MISALIGN_TRAP_EN, LW addr 0x2 -> misalign_trap pulse, dmem_req stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 load/store codes, FSM states and
// byte-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;
  localparam logic [2:0] F3Sd  = 3'b011;

  typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

  // Unshifted byte enables for an access size taken from funct3[1:0].
  function automatic logic [7:0] store_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: shifts the addressed bytes down to lane 0 and applies
// sign or zero extension according to funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3Lb:    data = {{56{shifted[7]}}, shifted[7:0]};
      F3Lh:    data = {{48{shifted[15]}}, shifted[15:0]};
      F3Lw:    data = {{32{shifted[31]}}, shifted[31:0]};
      F3Lbu:   data = {56'd0, shifted[7:0]};
      F3Lhu:   data = {48'd0, shifted[15:0]};
      F3Lwu:   data = {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-bus access per load/store, waits for the ack with a
// bounded timeout and forwards results toward MEM_WB. Define MISALIGN_TRAP_EN to trap
// misaligned halfword/word/doubleword accesses instead of performing them truncated.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] ALU_Result,
  input  logic [63:0] write_data,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        out_valid,
  output logic [63:0] read_data,
  output logic [63:0] ALU_Result_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        MemRead_out,
  output logic        bus_error,
  output logic        misalign_trap
);

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [2:0]  off_q;
  logic [2:0]  funct3_q;
  logic [2:0]  off;
  logic        mem_op;
  logic        trap;
  logic        timeout;
  logic [63:0] load_data;

  assign off    = ALU_Result[2:0];
  assign mem_op = MemRead | MemWrite;

`ifdef MISALIGN_TRAP_EN
  assign trap = in_valid & mem_op & misaligned(funct3[1:0], off);
`else
  assign trap = 1'b0;
`endif

  // wait_cnt_q counts completed wait cycles, so the current cycle is wait number cnt+1.
  assign timeout = (state_q == StWaitAck) && (wait_cnt_q == 8'(MAX_WAIT - 1));

  assign stall = ((state_q == StIdle) && in_valid && mem_op && !trap) ||
                 ((state_q == StWaitAck) && !dmem_ack && !timeout);

  mem_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      off_q          <= '0;
      funct3_q       <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= '0;
      out_valid      <= 1'b0;
      read_data      <= '0;
      ALU_Result_out <= '0;
      rd_out         <= '0;
      RegWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      bus_error      <= 1'b0;
      misalign_trap  <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      bus_error     <= 1'b0;
      misalign_trap <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ALU_Result_out <= ALU_Result;
            rd_out         <= rd;
            RegWrite_out   <= RegWrite;
            MemtoReg_out   <= MemtoReg;
            MemRead_out    <= MemRead;
            off_q          <= off;
            funct3_q       <= funct3;
            if (!mem_op) begin
              out_valid <= 1'b1;
              read_data <= '0;
            end else if (trap) begin
              out_valid     <= 1'b1;
              misalign_trap <= 1'b1;
              RegWrite_out  <= 1'b0;
              read_data     <= '0;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= {ALU_Result[63:3], 3'b000};
              // Lanes shifted past byte 7 fall off the top of the bus.
              dmem_wdata <= MemWrite ? (write_data << {off, 3'b000}) : '0;
              dmem_wstrb <= MemWrite ? (store_mask(funct3[1:0]) << off) : '0;
              wait_cnt_q <= '0;
              state_q    <= StWaitAck;
            end
          end
        end
        StWaitAck: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            out_valid <= 1'b1;
            read_data <= load_data;
            state_q   <= StIdle;
          end else if (timeout) begin
            dmem_req     <= 1'b0;
            out_valid    <= 1'b1;
            bus_error    <= 1'b1;
            RegWrite_out <= 1'b0;
            read_data    <= '0;
            state_q      <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts each result pulse
// and the bus request fields; a per-cycle compare process checks every output pulse.
module tb_mem_access_stage;

  localparam int unsigned MaxWait = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] ALU_Result;
  logic [63:0] write_data;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite, RegWrite, MemtoReg;
  logic        stall, dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        out_valid;
  logic [63:0] read_data, ALU_Result_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out, MemtoReg_out, MemRead_out, bus_error, misalign_trap;

  mem_access_stage #(.MAX_WAIT(MaxWait)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .ALU_Result     (ALU_Result),
    .write_data     (write_data),
    .rd             (rd),
    .funct3         (funct3),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .RegWrite       (RegWrite),
    .MemtoReg       (MemtoReg),
    .stall          (stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .out_valid      (out_valid),
    .read_data      (read_data),
    .ALU_Result_out (ALU_Result_out),
    .rd_out         (rd_out),
    .RegWrite_out   (RegWrite_out),
    .MemtoReg_out   (MemtoReg_out),
    .MemRead_out    (MemRead_out),
    .bus_error      (bus_error),
    .misalign_trap  (misalign_trap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  errors = 0;
  int  checks = 0;
  bit  cmp_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [63:0] alu;
    logic [4:0]  dest;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic [63:0] rdata;
    logic        berr;
    logic        trap;
  } exp_t;

  exp_t expq[$];

  logic [63:0] obs_addr, obs_wdata;
  logic [7:0]  obs_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: byte-oriented view of the bus ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] word, input logic [2:0] off,
                                             input logic [2:0] f3);
    logic [63:0] v;
    int n;
    v = '0;
    n = size_of(f3);
    for (int i = 0; i < n; i++)
      if (int'(off) + i < 8) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off) && i < int'(off) + size_of(f3)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) v[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    exp_t e;
    if (cmp_en) begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("out_valid", out_valid, 1'b1);
        chk("ALU_Result_out", ALU_Result_out, e.alu);
        chk("rd_out", rd_out, e.dest);
        chk("RegWrite_out", RegWrite_out, e.rw);
        chk("MemtoReg_out", MemtoReg_out, e.m2r);
        chk("MemRead_out", MemRead_out, e.mr);
        if (e.mr || e.berr || e.trap || !e.m2r) chk("read_data", read_data, e.rdata);
        chk("bus_error", bus_error, e.berr);
        chk("misalign_trap", misalign_trap, e.trap);
      end else begin
        chk("out_valid_idle", out_valid, 1'b0);
        chk("bus_error_idle", bus_error, 1'b0);
        chk("misalign_trap_idle", misalign_trap, 1'b0);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic alu_op(input logic [63:0] val, input logic [4:0] dest, input logic rw);
    @(posedge clk); #1;
    in_valid = 1'b1; ALU_Result = val; rd = dest; funct3 = 3'b000; write_data = '0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = rw; MemtoReg = 1'b0;
    expq.push_back('{cyc + 1, val, dest, rw, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0});
    #1 chk("stall_alu", stall, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dmem_req_alu", dmem_req, 1'b0);
  endtask

  // ack_after: cycles after the dmem_req rise at which ack is given; negative = never.
  task automatic mem_access(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input int ack_after, input logic [63:0] rdata,
                            input logic [4:0] dest, input logic rw);
    int t0;
    logic [2:0] off;
    off = addr[2:0];
    @(posedge clk); #1;
    in_valid = 1'b1; ALU_Result = addr; write_data = wd; rd = dest; funct3 = f3;
    MemRead = rd_en; MemWrite = wr_en; RegWrite = rw; MemtoReg = rd_en;
    t0 = cyc;
    #1 chk("stall_accept", stall, 1'b1);
    for (int k = 1; k <= int'(MaxWait); k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        obs_addr = dmem_addr; obs_wstrb = dmem_wstrb; obs_wdata = dmem_wdata;
      end
      chk("dmem_req", dmem_req, 1'b1);
      chk("dmem_addr", dmem_addr, {addr[63:3], 3'b000});
      chk("dmem_we", dmem_we, wr_en);
      if (wr_en) begin
        chk("dmem_wstrb", dmem_wstrb, model_wstrb(f3, off));
        chk("dmem_wdata", dmem_wdata, model_wdata(wd, off));
      end
      if (ack_after >= 0 && k == ack_after + 1) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
        expq.push_back('{t0 + k + 1, addr, dest, rw, rd_en, rd_en,
                         rd_en ? model_load(rdata, off, f3) : 64'd0, 1'b0, 1'b0});
        #1 chk("stall_ack", stall, 1'b0);
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = '0; in_valid = 1'b0;
        return;
      end
      #1 chk("stall_wait", stall, (k == int'(MaxWait)) ? 1'b0 : 1'b1);
    end
    expq.push_back('{t0 + int'(MaxWait) + 1, addr, dest, 1'b0, rd_en, rd_en, 64'd0,
                     1'b1, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dmem_req_abort", dmem_req, 1'b0);
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic trap_access(input logic [2:0] f3, input logic [63:0] addr,
                             input logic [4:0] dest);
    @(posedge clk); #1;
    in_valid = 1'b1; ALU_Result = addr; write_data = '0; rd = dest; funct3 = f3;
    MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
    expq.push_back('{cyc + 1, addr, dest, 1'b0, 1'b1, 1'b1, 64'd0, 1'b0, 1'b1});
    #1 chk("stall_trap", stall, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dmem_req_trap", dmem_req, 1'b0);
    chk("misalign_trap_lit", misalign_trap, 1'b1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1; in_valid = 1'b0; ALU_Result = '0; write_data = '0; rd = '0; funct3 = '0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_read_data", read_data, 64'd0);
    chk("rst_rd_out", rd_out, 5'd0);
    chk("rst_dmem_addr", dmem_addr, 64'd0);
    chk("rst_bus_error", bus_error, 1'b0);
    chk("rst_misalign_trap", misalign_trap, 1'b0);
    reset = 1'b0;
    cmp_en = 1'b1;

    alu_op(64'h1234, 5'd5, 1'b1);
    chk("alu_rd_out_lit", rd_out, 5'd5);
    chk("alu_out_valid_lit", out_valid, 1'b1);
    alu_op(64'hDEAD_BEEF_0000_0001, 5'd31, 1'b0);
    alu_op(64'h0, 5'd1, 1'b1);

    // LB sign extension with a 2-cycle ack latency
    mem_access(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 2, 64'h0000_0000_8000_0000, 5'd7, 1'b1);
    chk("lb_read_data_lit", read_data, 64'hFFFF_FFFF_FFFF_FF80);

    mem_access(1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 0, 64'd0, 5'd0, 1'b0);
    chk("sh_addr_lit", obs_addr, 64'h2000);
    chk("sh_wstrb_lit", obs_wstrb, 8'hC0);
    chk("sh_wdata_lit", obs_wdata, 64'hBEEF_0000_0000_0000);

    mem_access(1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 1, 64'h0000_0000_8000_0000, 5'd8, 1'b1);
    chk("lbu_lit", read_data, 64'h80);
    mem_access(1'b1, 1'b0, 3'b001, 64'h4002, 64'd0, 0, 64'h0000_0000_8001_0000, 5'd9, 1'b1);
    chk("lh_lit", read_data, 64'hFFFF_FFFF_FFFF_8001);
    mem_access(1'b1, 1'b0, 3'b101, 64'h4002, 64'd0, 3, 64'h0000_0000_8001_0000, 5'd9, 1'b1);
    mem_access(1'b1, 1'b0, 3'b010, 64'h4004, 64'd0, 0, 64'h8765_4321_0000_0000, 5'd10, 1'b1);
    chk("lw_lit", read_data, 64'hFFFF_FFFF_8765_4321);
    mem_access(1'b1, 1'b0, 3'b110, 64'h4004, 64'd0, 1, 64'h8765_4321_0000_0000, 5'd10, 1'b1);
    mem_access(1'b1, 1'b0, 3'b011, 64'h4008, 64'd0, 5, 64'hFEDC_BA98_7654_3210, 5'd11, 1'b1);
    mem_access(1'b1, 1'b0, 3'b111, 64'h4010, 64'd0, 0, 64'h8000_0000_0000_0001, 5'd12, 1'b1);
    mem_access(1'b0, 1'b1, 3'b000, 64'h5005, 64'h11AB, 0, 64'd0, 5'd0, 1'b0);
    chk("sb_wstrb_lit", obs_wstrb, 8'h20);
    mem_access(1'b0, 1'b1, 3'b010, 64'h5004, 64'hCAFE_F00D, 2, 64'd0, 5'd0, 1'b0);
    mem_access(1'b0, 1'b1, 3'b011, 64'h5000, 64'h0102_0304_0506_0708, 0, 64'd0, 5'd0, 1'b0);
    alu_op(64'h77, 5'd3, 1'b1);

    // LD with no ack: abort after MaxWait cycles of waiting
    mem_access(1'b1, 1'b0, 3'b011, 64'h6000, 64'd0, -1, 64'd0, 5'd13, 1'b1);
    chk("timeout_bus_error_lit", bus_error, 1'b1);
    chk("timeout_regwrite_lit", RegWrite_out, 1'b0);
    alu_op(64'h88, 5'd4, 1'b1);

    // Stray ack while idle must not produce a result
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;

`ifdef MISALIGN_TRAP_EN
    trap_access(3'b010, 64'h2, 5'd14);
    trap_access(3'b001, 64'h7001, 5'd15);
    trap_access(3'b011, 64'h7004, 5'd16);
`else
    mem_access(1'b1, 1'b0, 3'b010, 64'h6, 64'd0, 0, 64'h1234_5678_9ABC_DEF0, 5'd14, 1'b1);
    chk("lw_trunc_lit", read_data, 64'h1234);
    mem_access(1'b0, 1'b1, 3'b010, 64'h6, 64'hDEAD_BEEF, 1, 64'd0, 5'd0, 1'b0);
    chk("sw_trunc_wstrb_lit", obs_wstrb, 8'hC0);
    chk("sw_trunc_wdata_lit", obs_wdata, 64'hBEEF_0000_0000_0000);
    chk("misalign_trap_off", misalign_trap, 1'b0);
`endif

    // Reset in the middle of a wait, ack arriving just after
    @(posedge clk); #1;
    in_valid = 1'b1; ALU_Result = 64'h3000; rd = 5'd17; funct3 = 3'b011;
    MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    chk("rstw_req_up", dmem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 64'h5555;
    #1;
    chk("rstw_req_drop", dmem_req, 1'b0);
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_rd_out", rd_out, 5'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("rstw_req_after", dmem_req, 1'b0);
    chk("rstw_cycles", cyc - t0, 4);
    alu_op(64'h99, 5'd18, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
